game_fsm_param: RTL and testbench

//  Parametrised game-flow controller for the shooter. Sits between the collision/bullet/spawn logic
//  and the display/score blocks. Tracks lives, score, level and scene.

---
 rtl/game_fsm_param.sv | 180 ++++++++++++++++++
 tb/tb_game_fsm_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_param.sv
// game_fsm_param: game-flow controller for the shooter.
// Tracks scene, lives, score and level. Supports pause, a post-hit invulnerability
// window, saturating score/level arithmetic and several scoring events in one cycle.
// Optional feature macro: GAME_HISCORE_EN (keeps the best score across games).
module game_fsm_param #(
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_W     = 3,
  parameter int SCORE_W     = 20,
  parameter int LEVEL_W     = 5,
  parameter int LEVEL_MAX   = 31,
  parameter int LEVEL_SHIFT = 5,
  parameter int HIT_PTS     = 2,
  parameter int AVOID_PTS   = 1,
  parameter int INVULN_CYC  = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               colision,
  input  logic               bullet_hit,
  input  logic               swF_re,
  input  logic               pause_re,
  input  logic               spawned,
  input  logic               avoided,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         scene,
  output logic               invuln,
  output logic [SCORE_W-1:0] hiscore
);

  // Counter wide enough to hold INVULN_CYC; one bit minimum when the window is disabled.
  localparam int INV_W = (INVULN_CYC > 0) ? $clog2(INVULN_CYC + 1) : 1;
  // Headroom for the score sum so adding both point values cannot wrap before saturation.
  localparam int SUM_W = SCORE_W + 8;
  // Level threshold is compared at this width so level<<LEVEL_SHIFT never truncates.
  localparam int CMP_W = SCORE_W + LEVEL_W;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SPAWN   = 3'd2,
    S_PLAYING = 3'd3,
    S_PAUSED  = 3'd4,
    S_LOST    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         scene_q, scene_d;
  logic               invuln_q, invuln_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic               lost_entry;

  logic [SUM_W-1:0]   score_sum;
  logic [CMP_W-1:0]   level_thr;
  logic               level_up;

  // Datapath helpers: saturating score sum and level-up threshold test on registered values.
  always_comb begin
    score_sum = SUM_W'(score_q)
              + (bullet_hit ? SUM_W'(HIT_PTS) : SUM_W'(0))
              + (avoided    ? SUM_W'(AVOID_PTS) : SUM_W'(0));
    level_thr = CMP_W'(level_q) << LEVEL_SHIFT;
    level_up  = (CMP_W'(score_q) >= level_thr) && (level_q < LEVEL_W'(LEVEL_MAX));
  end

  // Next-state and next-value logic; everything holds unless a rule below changes it.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    level_d    = level_q;
    inv_cnt_d  = inv_cnt_q;
    lost_entry = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (swF_re) state_d = S_INIT;
      end
      S_INIT: begin
        lives_d   = LIVES_W'(LIVES_INIT);
        score_d   = '0;
        level_d   = LEVEL_W'(1);
        inv_cnt_d = '0;
        state_d   = S_SPAWN;
      end
      S_SPAWN: begin
        if (spawned) state_d = S_PLAYING;
      end
      S_PLAYING: begin
        // The invulnerability window runs down in every playing cycle.
        if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - INV_W'(1);
        if (pause_re) begin
          // Pause wins over every gameplay event in this cycle.
          state_d = S_PAUSED;
        end else if (lives_q == '0) begin
          // Game over: the events of this cycle are discarded.
          state_d    = S_LOST;
          lost_entry = 1'b1;
        end else begin
          score_d = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
          if (colision && (inv_cnt_q == '0)) begin
            lives_d   = lives_q - LIVES_W'(1);
            inv_cnt_d = INV_W'(INVULN_CYC);
          end
          if (level_up) level_d = level_q + LEVEL_W'(1);
        end
      end
      S_PAUSED: begin
        if (pause_re) state_d = S_PLAYING;
      end
      S_LOST: begin
        if (swF_re) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Scene and invuln are registered alongside the state they describe.
    unique case (state_d)
      S_PLAYING: scene_d = 2'd1;
      S_LOST:    scene_d = 2'd2;
      S_PAUSED:  scene_d = 2'd3;
      default:   scene_d = 2'd0;
    endcase
    invuln_d = (inv_cnt_d != '0);
  end

  // State and game-value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lives_q   <= LIVES_W'(LIVES_INIT);
      score_q   <= '0;
      level_q   <= LEVEL_W'(1);
      scene_q   <= 2'd0;
      invuln_q  <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      level_q   <= level_d;
      scene_q   <= scene_d;
      invuln_q  <= invuln_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;

  // Best score is captured as the game is lost; only reset clears it.
  always_comb begin
    hiscore_d = hiscore_q;
    if (lost_entry && (score_q > hiscore_q)) hiscore_d = score_q;
  end

  // High-score register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hiscore_q <= '0;
    else     hiscore_q <= hiscore_d;
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign level  = level_q;
  assign lives  = lives_q;
  assign score  = score_q;
  assign scene  = scene_q;
  assign invuln = invuln_q;

endmodule

// File: tb/tb_game_fsm_param.sv
// Testbench for game_fsm_param: directed scenarios followed by random play,
// every cycle compared against a behavioural model of the game rules.
module tb_game_fsm_param;

  localparam int LIVES_INIT  = 3;
  localparam int LIVES_W     = 3;
  localparam int SCORE_W     = 6;
  localparam int LEVEL_W     = 5;
  localparam int LEVEL_MAX   = 31;
  localparam int LEVEL_SHIFT = 5;
  localparam int HIT_PTS     = 2;
  localparam int AVOID_PTS   = 1;
  localparam int INVULN_CYC  = 10;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;
`ifdef GAME_HISCORE_EN
  localparam int HI_EN = 1;
`else
  localparam int HI_EN = 0;
`endif

  // Phases of the game as the model sees them.
  localparam int PH_IDLE  = 0;
  localparam int PH_INIT  = 1;
  localparam int PH_SPAWN = 2;
  localparam int PH_PLAY  = 3;
  localparam int PH_PAUSE = 4;
  localparam int PH_LOST  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic colision = 1'b0, bullet_hit = 1'b0, swF_re = 1'b0;
  logic pause_re = 1'b0, spawned = 1'b0, avoided = 1'b0;
  logic [LEVEL_W-1:0] level;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic [1:0]         scene;
  logic               invuln;
  logic [SCORE_W-1:0] hiscore;

  int checks = 0;
  int errors = 0;

  int m_ph, m_lives, m_score, m_level, m_inv, m_hi;

  game_fsm_param #(
    .LIVES_INIT(LIVES_INIT), .LIVES_W(LIVES_W), .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W),
    .LEVEL_MAX(LEVEL_MAX), .LEVEL_SHIFT(LEVEL_SHIFT), .HIT_PTS(HIT_PTS),
    .AVOID_PTS(AVOID_PTS), .INVULN_CYC(INVULN_CYC)
  ) dut (
    .clk(clk), .rst(rst), .colision(colision), .bullet_hit(bullet_hit), .swF_re(swF_re),
    .pause_re(pause_re), .spawned(spawned), .avoided(avoided), .level(level), .lives(lives),
    .score(score), .scene(scene), .invuln(invuln), .hiscore(hiscore)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = PH_IDLE; m_lives = LIVES_INIT; m_score = 0; m_level = 1; m_inv = 0; m_hi = 0;
  endtask

  function automatic int exp_scene();
    if (m_ph == PH_PLAY)  return 1;
    if (m_ph == PH_LOST)  return 2;
    if (m_ph == PH_PAUSE) return 3;
    return 0;
  endfunction

  // One clock of the game rules, applied to the inputs present at the edge.
  task automatic model_step();
    int ninv;
    int gain;
    bit lvl_up;
    case (m_ph)
      PH_IDLE:  if (swF_re) m_ph = PH_INIT;
      PH_INIT: begin
        m_lives = LIVES_INIT; m_score = 0; m_level = 1; m_inv = 0; m_ph = PH_SPAWN;
      end
      PH_SPAWN: if (spawned) m_ph = PH_PLAY;
      PH_PLAY: begin
        ninv = (m_inv > 0) ? m_inv - 1 : 0;
        if (pause_re) begin
          m_ph = PH_PAUSE;
        end else if (m_lives == 0) begin
          m_ph = PH_LOST;
          if (HI_EN != 0 && m_score > m_hi) m_hi = m_score;
        end else begin
          lvl_up = (m_score >= m_level * (1 << LEVEL_SHIFT)) && (m_level < LEVEL_MAX);
          gain = (bullet_hit ? HIT_PTS : 0) + (avoided ? AVOID_PTS : 0);
          m_score = (m_score + gain > SCORE_MAX) ? SCORE_MAX : m_score + gain;
          if (colision && m_inv == 0) begin
            m_lives = m_lives - 1;
            ninv = INVULN_CYC;
          end
          if (lvl_up) m_level = m_level + 1;
        end
        m_inv = ninv;
      end
      PH_PAUSE: if (pause_re) m_ph = PH_PLAY;
      PH_LOST:  if (swF_re) m_ph = PH_IDLE;
      default:  m_ph = PH_IDLE;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".scene"},   32'(scene),   32'(exp_scene()));
    check({tag, ".lives"},   32'(lives),   32'(m_lives));
    check({tag, ".score"},   32'(score),   32'(m_score));
    check({tag, ".level"},   32'(level),   32'(m_level));
    check({tag, ".invuln"},  32'(invuln),  32'(m_inv != 0));
    check({tag, ".hiscore"}, 32'(hiscore), 32'(m_hi));
    $display("[%0t] %s scene=%0d lives=%0d score=%0d level=%0d invuln=%0d hiscore=%0d",
             $time, tag, scene, lives, score, level, invuln, hiscore);
  endtask

  // Apply the currently driven inputs for one clock, then compare and clear pulses.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    colision = 0; bullet_hit = 0; swF_re = 0; pause_re = 0; spawned = 0; avoided = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic start_game();
    if (m_ph == PH_LOST) begin swF_re = 1; tick("to_idle"); end
    swF_re = 1; tick("swF");
    tick("init");
    spawned = 1; tick("spawned");
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin bullet_hit = 1; tick("hit"); end
  endtask

  // Spaced collisions until the game is lost; bounded by the number of lives.
  task automatic lose_game();
    for (int i = 0; i < LIVES_INIT + 2 && m_ph == PH_PLAY; i++) begin
      idle(INVULN_CYC + 1, "wait_inv");
      colision = 1; tick("col");
      if (m_lives == 0) idle(2, "to_lost");
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    check_all("reset");

    // Start a game: scene 0, 0, then 1.
    swF_re = 1; tick("t2.swF");
    check("t2.scene_a", 32'(scene), 32'd0);
    tick("t2.init");
    check("t2.scene_b", 32'(scene), 32'd0);
    spawned = 1; tick("t2.spawned");
    check("t2.scene_c", 32'(scene), 32'd1);
    avoided = 1; bullet_hit = 1; tick("t2.both");
    check("t2.score3", 32'(score), 32'd3);

    // Collision, then another inside the invulnerability window.
    colision = 1; tick("t3.col1");
    idle(4, "t3.gap");
    colision = 1; tick("t3.col2");
    check("t3.lives2", 32'(lives), 32'd2);
    idle(INVULN_CYC, "t3.drain");
    check("t3.inv_off", 32'(invuln), 32'd0);

    // Pause with the invulnerability window part-used; events while paused do nothing.
    colision = 1; tick("t5.col");
    idle(3, "t5.run");
    pause_re = 1; tick("t5.pause");
    check("t5.scene3", 32'(scene), 32'd3);
    bullet_hit = 1; colision = 1; tick("t5.ev");
    idle(20, "t5.wait");
    pause_re = 1; tick("t5.resume");
    check("t5.scene1", 32'(scene), 32'd1);
    check("t5.lives1", 32'(lives), 32'd1);
    idle(INVULN_CYC, "t5.drain");

    // Last life lost: LOST two cycles later; scoring ignored afterwards.
    colision = 1; tick("t4.col3");
    check("t4.lives0", 32'(lives), 32'd0);
    tick("t4.entry");
    check("t4.scene2", 32'(scene), 32'd2);
    bullet_hit = 1; tick("t4.hit");
    check("t4.score", 32'(score), 32'd3);

    // Reset in the middle of a game with score 7 and one life.
    start_game();
    hits(3);
    avoided = 1; tick("t1.av");
    lose_game();
    // lose_game ran to LOST; replay to reach the mid-game state with one life.
    start_game();
    hits(3);
    avoided = 1; tick("t1.av");
    idle(1, "t1.x");
    colision = 1; tick("t1.c1");
    idle(INVULN_CYC + 1, "t1.w");
    colision = 1; tick("t1.c2");
    check("t1.pre_score", 32'(score), 32'd7);
    #2 rst = 1;
    #1;
    model_reset();
    check_all("t1.rst");
    check("t1.lives", 32'(lives), 32'd3);
    #1 rst = 0;

    // Level-up at 32, then finish game 1 at 40 and game 2 at 25.
    start_game();
    hits(16);
    check("t6.lvl1", 32'(level), 32'd1);
    tick("t6.lvlup");
    check("t6.lvl2", 32'(level), 32'd2);
    hits(4);
    lose_game();
    start_game();
    hits(12);
    avoided = 1; tick("t6.av");
    lose_game();
    check("t6.hiscore", 32'(hiscore), (HI_EN != 0) ? 32'd40 : 32'd0);

    // Saturation at 63.
    start_game();
    hits(31);
    check("t6.score62", 32'(score), 32'd62);
    bullet_hit = 1; tick("t6.sat");
    check("t6.score63", 32'(score), 32'd63);
    bullet_hit = 1; avoided = 1; tick("t6.sat2");
    check("t6.score63b", 32'(score), 32'd63);

    // Random play.
    for (int i = 0; i < 800; i++) begin
      colision   = ($urandom_range(0, 9) == 0);
      bullet_hit = ($urandom_range(0, 2) == 0);
      avoided    = ($urandom_range(0, 4) == 0);
      pause_re   = ($urandom_range(0, 39) == 0);
      swF_re     = ($urandom_range(0, 14) == 0);
      spawned    = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
